// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake, and
// holds the fetched word for the controller while it executes.
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        stall,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic [3:0]  Cond,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rd,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_EXEC  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] wait_cnt;
    logic        timeout_hit;

    // The cycle that would bring the wait count up to TIMEOUT is the one that faults.
    assign timeout_hit = (TIMEOUT != 0) && ((wait_cnt + 32'd1) == 32'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (imem_ack) begin
                    state_next = S_EXEC;
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    state_next = S_REQ;
                end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        imem_req   = (state == S_REQ) && !rst;
        InstrValid = (state == S_EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PC          <= RESET_PC;
            Instr       <= 32'd0;
            wait_cnt    <= 32'd0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        Instr <= imem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                        if (timeout_hit) begin
                            fetch_fault <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        // Redirect targets are forced word-aligned.
                        PC       <= PCSrc ? (Result & 32'hFFFF_FFFC) : (PC + 32'd4);
                        wait_cnt <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = PC;
    assign PCPlus8   = PC + 32'd8;
    assign Cond      = Instr[31:28];
    assign Op        = Instr[27:26];
    assign Funct     = Instr[25:20];
    assign Rd        = Instr[15:12];

endmodule
